// File: rtl/regfile_scoreboard.sv
// Multi-read-port register file with same-cycle write bypass and a busy-bit
// scoreboard that tracks in-flight destination registers for the decode stage.
module regfile_scoreboard #(
    parameter int unsigned XLEN     = 64,
    parameter int unsigned NREGS    = 32,
    parameter int unsigned NRD      = 2,
    parameter int unsigned ZERO_REG = 1,
    localparam int unsigned AW      = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    output logic                stall,
    input  logic [NRD-1:0]      rd_used,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [XLEN-1:0]     wr_data,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_addr,
    output logic                iss_ok
);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy;
    logic             wr_zero;
    logic             iss_zero;
    logic             iss_retiring;

    assign wr_zero      = (ZERO_REG != 0) && (wr_addr == '0);
    assign iss_zero     = (ZERO_REG != 0) && (iss_addr == '0);
    assign iss_retiring = wr_en && (wr_addr == iss_addr);

    // A pending destination may be reissued only if it retires this same cycle.
    assign iss_ok = iss_en && !reset && !(busy[iss_addr] && !iss_retiring);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
            busy <= '0;
        end else begin
            if (wr_en && !wr_zero) begin
                regs[wr_addr] <= wr_data;
                busy[wr_addr] <= 1'b0;
            end
            // Issue follows the write so the younger instruction's busy bit wins.
            if (iss_ok && !iss_zero) begin
                busy[iss_addr] <= 1'b1;
            end
        end
    end

    for (genvar p = 0; p < NRD; p++) begin : g_port
        logic [AW-1:0]   addr;
        logic            zero;
        logic            hit;
        logic [XLEN-1:0] data;
        logic            pend;

        assign addr = rd_addr[p*AW +: AW];
        assign zero = (ZERO_REG != 0) && (addr == '0);
        assign hit  = wr_en && (wr_addr == addr);

        always_comb begin
            data = '0;
            pend = 1'b0;
            if (!reset && !zero) begin
                if (hit) begin
                    data = wr_data;
                end else begin
                    data = regs[addr];
                    pend = busy[addr];
                end
            end
        end

        assign rd_data[p*XLEN +: XLEN] = data;
        assign rd_busy[p]              = pend;
    end

    assign stall = |(rd_busy & rd_used);

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: default configuration plus a 32-bit/16-reg/3-port
// instance without a hard-wired zero register, both checked against a shared model.
module tb_regfile_scoreboard;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    // configuration 0: defaults
    logic [9:0]   a_rd_addr;
    logic [127:0] a_rd_data;
    logic [1:0]   a_rd_busy, a_rd_used;
    logic         a_stall, a_wr_en, a_iss_en, a_iss_ok;
    logic [4:0]   a_wr_addr, a_iss_addr;
    logic [63:0]  a_wr_data;

    // configuration 1: XLEN=32, NREGS=16, NRD=3, ZERO_REG=0
    logic [11:0]  b_rd_addr;
    logic [95:0]  b_rd_data;
    logic [2:0]   b_rd_busy, b_rd_used;
    logic         b_stall, b_wr_en, b_iss_en, b_iss_ok;
    logic [3:0]   b_wr_addr, b_iss_addr;
    logic [31:0]  b_wr_data;

    regfile_scoreboard u_dut_a (
        .clk(clk), .reset(reset), .rd_addr(a_rd_addr), .rd_data(a_rd_data),
        .rd_busy(a_rd_busy), .stall(a_stall), .rd_used(a_rd_used),
        .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
        .iss_en(a_iss_en), .iss_addr(a_iss_addr), .iss_ok(a_iss_ok)
    );

    regfile_scoreboard #(.XLEN(32), .NREGS(16), .NRD(3), .ZERO_REG(0)) u_dut_b (
        .clk(clk), .reset(reset), .rd_addr(b_rd_addr), .rd_data(b_rd_data),
        .rd_busy(b_rd_busy), .stall(b_stall), .rd_used(b_rd_used),
        .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .iss_en(b_iss_en), .iss_addr(b_iss_addr), .iss_ok(b_iss_ok)
    );

    localparam int NR[2]  = '{32, 16};
    localparam int ND[2]  = '{2, 3};
    localparam bit ZR[2]  = '{1'b1, 1'b0};
    localparam logic [63:0] XM[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF};

    // stimulus for the current cycle, per configuration
    bit          s_rst;
    bit          s_we [2];
    int          s_wa [2];
    logic [63:0] s_wd [2];
    bit          s_ie [2];
    int          s_ia [2];
    int          s_ra [2][4];
    bit          s_ru [2][4];

    // architectural model
    logic [63:0] mreg  [2][32];
    bit          mbusy [2][32];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [63:0] exp_data(input int c, input int p);
        int a = s_ra[c][p];
        if (s_rst || (ZR[c] && a == 0)) return 64'd0;
        if (s_we[c] && s_wa[c] == a) return s_wd[c] & XM[c];
        return mreg[c][a];
    endfunction

    function automatic bit exp_busy(input int c, input int p);
        int a = s_ra[c][p];
        if (s_rst || (ZR[c] && a == 0)) return 1'b0;
        if (s_we[c] && s_wa[c] == a) return 1'b0;
        return mbusy[c][a];
    endfunction

    function automatic bit exp_stall(input int c);
        bit st = 1'b0;
        for (int p = 0; p < ND[c]; p++) st |= s_ru[c][p] & exp_busy(c, p);
        return st;
    endfunction

    function automatic bit exp_iss(input int c);
        if (!s_ie[c] || s_rst) return 1'b0;
        return !(mbusy[c][s_ia[c]] && !(s_we[c] && s_wa[c] == s_ia[c]));
    endfunction

    function automatic logic [63:0] act_data(input int c, input int p);
        if (c == 0) return a_rd_data[p*64 +: 64];
        return {32'd0, b_rd_data[p*32 +: 32]};
    endfunction

    function automatic logic act_busy(input int c, input int p);
        return (c == 0) ? a_rd_busy[p] : b_rd_busy[p];
    endfunction

    task automatic idle();
        s_rst = 1'b0;
        for (int c = 0; c < 2; c++) begin
            s_we[c] = 1'b0; s_wa[c] = 0; s_wd[c] = '0;
            s_ie[c] = 1'b0; s_ia[c] = 0;
            for (int p = 0; p < 4; p++) begin
                s_ra[c][p] = 0; s_ru[c][p] = 1'b0;
            end
        end
    endtask

    task automatic drive();
        logic [63:0] wa, ia, ra;
        reset = s_rst;
        wa = 64'(s_wa[0]); ia = 64'(s_ia[0]);
        a_wr_en = s_we[0]; a_wr_addr = wa[4:0]; a_wr_data = s_wd[0];
        a_iss_en = s_ie[0]; a_iss_addr = ia[4:0];
        for (int p = 0; p < 2; p++) begin
            ra = 64'(s_ra[0][p]);
            a_rd_addr[p*5 +: 5] = ra[4:0];
            a_rd_used[p] = s_ru[0][p];
        end
        wa = 64'(s_wa[1]); ia = 64'(s_ia[1]); ra = s_wd[1];
        b_wr_en = s_we[1]; b_wr_addr = wa[3:0]; b_wr_data = ra[31:0];
        b_iss_en = s_ie[1]; b_iss_addr = ia[3:0];
        for (int p = 0; p < 3; p++) begin
            ra = 64'(s_ra[1][p]);
            b_rd_addr[p*4 +: 4] = ra[3:0];
            b_rd_used[p] = s_ru[1][p];
        end
    endtask

    // Single compare point: every output of both instances against the model.
    task automatic check_model();
        for (int c = 0; c < 2; c++) begin
            for (int p = 0; p < ND[c]; p++) begin
                chk($sformatf("cfg%0d_rd_data%0d", c, p), act_data(c, p), exp_data(c, p));
                chk($sformatf("cfg%0d_rd_busy%0d", c, p), 64'(act_busy(c, p)), 64'(exp_busy(c, p)));
            end
            chk($sformatf("cfg%0d_stall", c), 64'((c == 0) ? a_stall : b_stall), 64'(exp_stall(c)));
            chk($sformatf("cfg%0d_iss_ok", c), 64'((c == 0) ? a_iss_ok : b_iss_ok), 64'(exp_iss(c)));
        end
    endtask

    task automatic update_model();
        for (int c = 0; c < 2; c++) begin
            bit ok = exp_iss(c);
            if (s_rst) begin
                for (int r = 0; r < 32; r++) begin
                    mreg[c][r] = '0; mbusy[c][r] = 1'b0;
                end
            end else begin
                if (s_we[c] && !(ZR[c] && s_wa[c] == 0)) begin
                    mreg[c][s_wa[c]]  = s_wd[c] & XM[c];
                    mbusy[c][s_wa[c]] = 1'b0;
                end
                if (ok && !(ZR[c] && s_ia[c] == 0)) mbusy[c][s_ia[c]] = 1'b1;
            end
        end
    endtask

    task automatic begin_cycle();
        drive();
        @(negedge clk);
        check_model();
    endtask

    task automatic end_cycle();
        @(posedge clk);
        update_model();
        #1;
    endtask

    function automatic int rand_addr(input int c);
        if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, NR[c] - 1));
        return int'($urandom_range(0, 5));
    endfunction

    initial begin
        for (int c = 0; c < 2; c++)
            for (int r = 0; r < 32; r++) begin
                mreg[c][r] = '0; mbusy[c][r] = 1'b0;
            end
        idle();
        s_rst = 1'b1;
        drive();
        @(posedge clk);
        #1;

        // reset cycle with activity on every input: all outputs forced low
        s_rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            s_we[c] = 1'b1; s_wa[c] = 3; s_wd[c] = 64'h55;
            s_ie[c] = 1'b1; s_ia[c] = 4; s_ra[c][0] = 3; s_ru[c][0] = 1'b1;
        end
        begin_cycle();
        chk("rst_iss_ok", 64'(a_iss_ok), 64'd0);
        chk("rst_bypass_masked", a_rd_data[63:0], 64'd0);
        end_cycle();

        // sweep every address on every port after reset
        for (int k = 0; k < 32; k++) begin
            idle();
            for (int p = 0; p < 4; p++) begin
                s_ra[0][p] = k; s_ra[1][p] = k % 16; s_ru[0][p] = 1'b1; s_ru[1][p] = 1'b1;
            end
            begin_cycle();
            chk("sweep_rd0", a_rd_data[63:0], 64'd0);
            chk("sweep_rd1", a_rd_data[127:64], 64'd0);
            chk("sweep_stall", 64'(a_stall), 64'd0);
            end_cycle();
        end

        // write r5 with same-cycle bypass, then array readback
        idle(); s_we[0] = 1'b1; s_wa[0] = 5; s_wd[0] = 64'h1234; s_ra[0][0] = 5;
        begin_cycle(); chk("bypass_r5", a_rd_data[63:0], 64'h1234); end_cycle();
        idle(); s_ra[0][0] = 5; s_ra[0][1] = 5;
        begin_cycle();
        chk("array_r5", a_rd_data[63:0], 64'h1234);
        chk("array_r5_p1", a_rd_data[127:64], 64'h1234);
        end_cycle();
        idle(); s_we[0] = 1'b1; s_wa[0] = 0; s_wd[0] = 64'hFF; s_ra[0][0] = 0;
        begin_cycle(); chk("r0_bypass", a_rd_data[63:0], 64'd0); end_cycle();
        idle(); s_ra[0][0] = 0;
        begin_cycle(); chk("r0_array", a_rd_data[63:0], 64'd0); end_cycle();

        // scoreboard: issue, stall, WAW refusal, release by writeback
        idle(); s_ie[0] = 1'b1; s_ia[0] = 7;
        begin_cycle(); chk("iss_r7", 64'(a_iss_ok), 64'd1); end_cycle();
        idle(); s_ra[0][0] = 7; s_ru[0][0] = 1'b1; s_ie[0] = 1'b1; s_ia[0] = 7;
        begin_cycle();
        chk("r7_busy", 64'(a_rd_busy[0]), 64'd1);
        chk("r7_stall", 64'(a_stall), 64'd1);
        chk("r7_waw", 64'(a_iss_ok), 64'd0);
        end_cycle();
        idle(); s_ra[0][0] = 7; s_ru[0][0] = 1'b1; s_we[0] = 1'b1; s_wa[0] = 7; s_wd[0] = 64'd42;
        begin_cycle();
        chk("r7_wb_data", a_rd_data[63:0], 64'd42);
        chk("r7_wb_stall", 64'(a_stall), 64'd0);
        end_cycle();
        idle(); s_ie[0] = 1'b1; s_ia[0] = 0;
        begin_cycle(); chk("iss_r0", 64'(a_iss_ok), 64'd1); end_cycle();

        // simultaneous write and issue, same and different registers
        idle(); s_ie[0] = 1'b1; s_ia[0] = 9;
        begin_cycle(); end_cycle();
        idle(); s_we[0] = 1'b1; s_wa[0] = 9; s_wd[0] = 64'h99; s_ie[0] = 1'b1; s_ia[0] = 9;
        begin_cycle(); chk("r9_wr_iss_ok", 64'(a_iss_ok), 64'd1); end_cycle();
        idle(); s_ra[0][0] = 9;
        begin_cycle();
        chk("r9_data", a_rd_data[63:0], 64'h99);
        chk("r9_still_busy", 64'(a_rd_busy[0]), 64'd1);
        end_cycle();
        idle(); s_ie[0] = 1'b1; s_ia[0] = 3;
        begin_cycle(); end_cycle();
        idle(); s_we[0] = 1'b1; s_wa[0] = 3; s_wd[0] = 64'h3; s_ie[0] = 1'b1; s_ia[0] = 4;
        begin_cycle(); end_cycle();
        idle(); s_ra[0][0] = 3; s_ra[0][1] = 4;
        begin_cycle();
        chk("r3_free", 64'(a_rd_busy[0]), 64'd0);
        chk("r4_busy", 64'(a_rd_busy[1]), 64'd1);
        end_cycle();

        // reset mid-operation discards the pending write
        idle(); s_we[0] = 1'b1; s_wa[0] = 2; s_wd[0] = 64'd77;
        begin_cycle(); end_cycle();
        idle(); s_ie[0] = 1'b1; s_ia[0] = 2;
        begin_cycle(); end_cycle();
        idle(); s_rst = 1'b1; s_we[0] = 1'b1; s_wa[0] = 2; s_wd[0] = 64'd5; s_ie[0] = 1'b1; s_ia[0] = 6;
        begin_cycle(); chk("midrst_iss_ok", 64'(a_iss_ok), 64'd0); end_cycle();
        idle(); s_ra[0][0] = 2; s_ru[0][0] = 1'b1;
        begin_cycle();
        chk("midrst_r2_data", a_rd_data[63:0], 64'd0);
        chk("midrst_r2_busy", 64'(a_rd_busy[0]), 64'd0);
        end_cycle();

        // second configuration: writable r0 and three independent ports
        idle(); s_we[1] = 1'b1; s_wa[1] = 0; s_wd[1] = 64'hABCD; s_ra[1][0] = 0;
        begin_cycle(); chk("b_r0_bypass", b_rd_data[31:0], 64'hABCD); end_cycle();
        idle(); s_ie[1] = 1'b1; s_ia[1] = 0;
        begin_cycle(); chk("b_r0_iss", 64'(b_iss_ok), 64'd1); end_cycle();
        idle(); s_ra[1][0] = 0; s_we[1] = 1'b1; s_wa[1] = 1; s_wd[1] = 64'd11;
        begin_cycle(); chk("b_r0_busy", 64'(b_rd_busy[0]), 64'd1); end_cycle();
        idle(); s_we[1] = 1'b1; s_wa[1] = 2; s_wd[1] = 64'd22;
        begin_cycle(); end_cycle();
        idle(); s_we[1] = 1'b1; s_wa[1] = 3; s_wd[1] = 64'd33;
        s_ra[1][0] = 3; s_ra[1][1] = 1; s_ra[1][2] = 2;
        begin_cycle();
        chk("b_p0", b_rd_data[31:0], 64'd33);
        chk("b_p1", b_rd_data[63:32], 64'd11);
        chk("b_p2", b_rd_data[95:64], 64'd22);
        end_cycle();

        // randomized traffic on both instances
        for (int n = 0; n < 2000; n++) begin
            idle();
            s_rst = ($urandom_range(0, 49) == 0);
            for (int c = 0; c < 2; c++) begin
                s_we[c] = $urandom_range(0, 1);
                s_wa[c] = rand_addr(c);
                s_wd[c] = {$urandom, $urandom};
                s_ie[c] = $urandom_range(0, 1);
                s_ia[c] = rand_addr(c);
                for (int p = 0; p < 4; p++) begin
                    s_ra[c][p] = rand_addr(c);
                    s_ru[c][p] = $urandom_range(0, 1);
                end
            end
            begin_cycle();
            end_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
